// File: rtl/mem_instr_sequencer.sv
// mem_instr_sequencer: control-step sequencer for ld/ldi/st that stretches memory
// steps on mem_ready and traps a memory access that never completes.
module mem_instr_sequencer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Read,
    output logic        Write,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Gra,
    output logic        Grb,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        alu_add,
    output logic        done,
    output logic        illegal,
    output logic        fault,
    output logic [3:0]  state
);
    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
        T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
        IDLE = 4'd8, FAULT = 4'd9
    } state_t;

    state_t     state_q, state_d, end_d;
    logic [7:0] wait_q, wait_d;
    logic [4:0] op;
    logic       is_ld, is_ldi, is_st, legal, mem_step, timeout;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign is_ld     = op == 5'b00000;
    assign is_ldi    = op == 5'b00001;
    assign is_st     = op == 5'b00010;
    assign legal     = is_ld || is_ldi || is_st;
    assign end_d     = run ? T0 : IDLE;
    assign mem_step  = state_q == T1 || (state_q == T6 && is_ld) || (state_q == T7 && is_st);
    assign timeout   = mem_step && !mem_ready && wait_q == 8'(WAIT_LIMIT - 1);
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // The counter only grows while a memory step is held, so it is zero on every entry.
    always_comb begin
        state_d = state_q;
        wait_d  = (mem_step && !mem_ready) ? wait_q + 8'd1 : 8'd0;
        {PCout, PCin, IncPC, MARin, Zin, Zlowout, Read, Write, MDRin, MDRout, IRin} = '0;
        {Yin, Gra, Grb, Rin, Rout, BAout, Cout, alu_add, done, illegal, fault} = '0;
        case (state_q)
            IDLE: state_d = run ? T0 : IDLE;
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = T1;
            end
            T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                PCin    = mem_ready;
                state_d = mem_ready ? T2 : T1;
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                Grb     = legal;
                BAout   = legal;
                Yin     = legal;
                illegal = !legal;
                state_d = legal ? T4 : end_d;
            end
            T4: begin
                Cout    = 1'b1;
                alu_add = 1'b1;
                Zin     = 1'b1;
                state_d = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                Gra     = is_ldi;
                Rin     = is_ldi;
                done    = is_ldi;
                MARin   = !is_ldi;
                state_d = is_ldi ? end_d : T6;
            end
            T6: begin
                Read    = is_ld;
                MDRin   = 1'b1;
                Gra     = !is_ld;
                Rout    = !is_ld;
                state_d = (is_ld && !mem_ready) ? T6 : T7;
            end
            T7: begin
                Write   = is_st;
                MDRout  = is_ld;
                Gra     = is_ld;
                Rin     = is_ld;
                done    = is_ld || (is_st && mem_ready);
                state_d = (is_st && !mem_ready) ? T7 : end_d;
            end
            FAULT: fault = 1'b1;
            default: state_d = IDLE;
        endcase
        if (timeout)
            state_d = FAULT;
    end
endmodule

// File: tb/tb_mem_instr_sequencer.sv
// tb_mem_instr_sequencer: directed and randomized instruction streams checked
// cycle by cycle against a step-list model built from the instruction rules.
module tb_mem_instr_sequencer;
    localparam int WL = 15;

    localparam logic [21:0] PCOUT = 22'd1 << 21, PCIN = 22'd1 << 20, INCPC = 22'd1 << 19;
    localparam logic [21:0] MARIN = 22'd1 << 18, ZIN = 22'd1 << 17, ZLOWOUT = 22'd1 << 16;
    localparam logic [21:0] READ = 22'd1 << 15, WRITE = 22'd1 << 14, MDRIN = 22'd1 << 13;
    localparam logic [21:0] MDROUT = 22'd1 << 12, IRIN = 22'd1 << 11, YIN = 22'd1 << 10;
    localparam logic [21:0] GRA = 22'd1 << 9, GRB = 22'd1 << 8, RIN = 22'd1 << 7;
    localparam logic [21:0] ROUT = 22'd1 << 6, BAOUT = 22'd1 << 5, COUT = 22'd1 << 4;
    localparam logic [21:0] ALUADD = 22'd1 << 3, DONE = 22'd1 << 2, ILLEGAL = 22'd1 << 1;
    localparam logic [21:0] FAULTB = 22'd1;

    logic        clk = 1'b0;
    logic        clr, run, mem_ready;
    logic [31:0] ir;
    logic        PCout, PCin, IncPC, MARin, Zin, Zlowout, Read, Write, MDRin, MDRout, IRin;
    logic        Yin, Gra, Grb, Rin, Rout, BAout, Cout, alu_add, done, illegal, fault;
    logic [3:0]  state;
    logic [21:0] obs;

    typedef struct {
        logic [3:0]  st;
        logic [21:0] ctl;
        logic        rdy;
        logic        last;
    } step_t;

    step_t q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    bit    at_idle;

    always #5 clk = ~clk;

    mem_instr_sequencer #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Zin(Zin),
        .Zlowout(Zlowout), .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Cout(Cout), .alu_add(alu_add), .done(done), .illegal(illegal),
        .fault(fault), .state(state)
    );

    assign obs = {PCout, PCin, IncPC, MARin, Zin, Zlowout, Read, Write, MDRin, MDRout, IRin,
                  Yin, Gra, Grb, Rin, Rout, BAout, Cout, alu_add, done, illegal, fault};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_st, input logic [21:0] exp_ctl);
        #1;
        n_tests += 2;
        assert (state === exp_st) else begin
            n_fail++;
            $error("FAIL %s state=%0d expected %0d", tag, state, exp_st);
        end
        assert (obs === exp_ctl) else begin
            n_fail++;
            $error("FAIL %s ctl=%h expected %h", tag, obs, exp_ctl);
        end
    endtask

    task automatic add(input logic [3:0] s, input logic [21:0] c, input logic r, input logic l);
        q.push_back('{s, c, r, l});
    endtask

    task automatic go_t0;
        if (at_idle) begin
            run = 1'b1;
            mem_ready = 1'($urandom);
            check("idle", 4'd8, '0);
            tick;
            at_idle = 1'b0;
        end
    endtask

    // Expected step list of one instruction: waits stretch memory steps, run only matters at the end.
    task automatic do_instr(input string tag, input logic [4:0] op, input int w1, input int w2,
                            input logic run_end);
        logic legal;
        legal = op <= 5'd2;
        q.delete();
        go_t0;
        add(0, PCOUT | MARIN | INCPC | ZIN, 1'($urandom), 0);
        for (int i = 0; i < w1; i++) add(1, ZLOWOUT | READ | MDRIN, 0, 0);
        add(1, ZLOWOUT | READ | MDRIN | PCIN, 1, 0);
        add(2, MDROUT | IRIN, 1'($urandom), 0);
        if (!legal) add(3, ILLEGAL, 1'($urandom), 1);
        else begin
            add(3, GRB | BAOUT | YIN, 1'($urandom), 0);
            add(4, COUT | ALUADD | ZIN, 1'($urandom), 0);
            if (op == 5'd1) add(5, ZLOWOUT | GRA | RIN | DONE, 1'($urandom), 1);
            else begin
                add(5, ZLOWOUT | MARIN, 1'($urandom), 0);
                if (op == 5'd0) begin
                    for (int i = 0; i < w2; i++) add(6, READ | MDRIN, 0, 0);
                    add(6, READ | MDRIN, 1, 0);
                    add(7, MDROUT | GRA | RIN | DONE, 1'($urandom), 1);
                end else begin
                    add(6, GRA | ROUT | MDRIN, 1'($urandom), 0);
                    for (int i = 0; i < w2; i++) add(7, WRITE, 0, 0);
                    add(7, WRITE | DONE, 1, 1);
                end
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            ir = (q[i].st < 4'd3) ? $urandom : {op, 27'($urandom)};
            mem_ready = q[i].rdy;
            run = q[i].last ? run_end : 1'($urandom);
            check(tag, q[i].st, q[i].ctl);
            tick;
        end
        at_idle = !run_end;
    endtask

    initial begin
        logic [4:0] op;
        int w1, w2;
        clr = 1'b0;
        run = 1'b1;
        mem_ready = 1'b1;
        ir = '0;
        tick;
        tick;
        check("reset", 4'd8, '0);
        clr = 1'b1;
        check("reset_release", 4'd8, '0);
        tick;
        at_idle = 1'b0;
        do_instr("ldi", 5'b00001, 0, 0, 1'b1);
        do_instr("ld_waits", 5'b00000, 3, 2, 1'b1);
        do_instr("st_drop_run", 5'b00010, 0, 3, 1'b0);
        check("st_after_idle", 4'd8, '0);
        do_instr("illegal", 5'b11111, 0, 0, 1'b1);
        do_instr("ready_on_limit", 5'b00000, WL - 1, WL - 1, 1'b1);
        do_instr("st_ready_on_limit", 5'b00010, 2, WL - 1, 1'b1);
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 3) == 3) ? 5'($urandom_range(3, 31)) : 5'($urandom_range(0, 2));
            w1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WL - 1) : $urandom_range(0, 2);
            w2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WL - 1) : $urandom_range(0, 2);
            do_instr("random", op, w1, w2, 1'($urandom));
        end
        go_t0;
        ir = $urandom;
        run = 1'b1;
        check("fault_t0", 4'd0, PCOUT | MARIN | INCPC | ZIN);
        tick;
        for (int i = 0; i < WL; i++) begin
            mem_ready = 1'b0;
            run = 1'($urandom);
            check("fault_wait", 4'd1, ZLOWOUT | READ | MDRIN);
            tick;
        end
        for (int i = 0; i < 4; i++) begin
            run = 1'($urandom);
            mem_ready = 1'($urandom);
            check("fault_hold", 4'd9, FAULTB);
            tick;
        end
        clr = 1'b0;
        run = 1'b1;
        check("fault_clr_pending", 4'd9, FAULTB);
        tick;
        check("fault_cleared", 4'd8, '0);
        clr = 1'b1;
        tick;
        at_idle = 1'b0;
        do_instr("after_fault", 5'b00000, 1, 1, 1'b1);
        clr = 1'b0;
        tick;
        check("mid_reset", 4'd8, '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_instr_sequencer.md
# mem_instr_sequencer

Control-step sequencer for the processor's memory-class instructions (ld, ldi, st). It drives the datapath control lines (PC, MAR/MDR, Y/Z, IR, register-select/Gra/Grb/Rin/Rout and BAout) through fetch and execute steps. It stretches memory steps on a ready handshake and traps a hung memory access. It sits between the instruction register and the bus/register-file datapath and is the only source of BAout to the register file.

## Interface
Parameters:
- WAIT_LIMIT, default 15, range 1..255: the number of consecutive not-ready cycles in a memory step that is treated as a fault.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset, synchronous, active-low.
- run  in  1  level request to execute instructions; sampled in IDLE and at instruction end.
- ir  in  32  instruction register contents; opcode is ir[31:27]; valid from T3 onward.
- mem_ready  in  1  memory access complete this cycle.
- PCout, PCin, IncPC, MARin, Zin, Zlowout, Read, Write, MDRin, MDRout, IRin, Yin, Gra, Grb, Rin, Rout, BAout, Cout, alu_add  out  1 each  datapath control lines, active-high.
- done  out  1  high during the final step of a completed instruction.
- illegal  out  1  one-cycle pulse in T3 when the opcode is not ld/ldi/st.
- fault  out  1  high while in FAULT.
- state  out  4  current state: T0..T7 are 0..7, IDLE is 8, FAULT is 9.

## Operation
- Opcodes: ld is 00000, ldi is 00001, st is 00010. Any other opcode is illegal.
- Outputs are decoded combinationally from the registered state plus ir[31:27]. Any line not listed for a step is 0.
- IDLE: all control lines 0. If run=1, go to T0; otherwise stay.
- T0: PCout, MARin, IncPC, Zin.
- T1 (memory step): Zlowout, PCin, Read, MDRin.
  - PCin is asserted only in the exit cycle, i.e. when mem_ready=1.
  - Hold T1 while mem_ready=0; otherwise go to T2.
- T2: MDRout, IRin.
- T3:
  - For ld/ldi/st: Grb, BAout, Yin. BAout makes rb=R0 read as zero, giving absolute addressing.
  - For an illegal opcode: no control lines, illegal=1, and the instruction ends.
- T4: Cout, alu_add, Zin.
- T5:
  - ld/st: Zlowout, MARin.
  - ldi: Zlowout, Gra, Rin, done. The instruction ends.
- T6:
  - ld (memory step): Read, MDRin. Hold while mem_ready=0.
  - st: Gra, Rout, MDRin.
- T7:
  - ld: MDRout, Gra, Rin, done. The instruction ends.
  - st (memory step): Write. Hold while mem_ready=0. done is asserted in the exit cycle (mem_ready=1), then the instruction ends.
- Instruction end: go to T0 if run=1, else IDLE. Dropping run mid-instruction never aborts the instruction.
- Wait counter (8 bits):
  - Cleared on entry to any memory step (T1, ld-T6, st-T7).
  - In a memory step with mem_ready=0: if count==WAIT_LIMIT-1, go to FAULT; else count+1.
  - Consequence: ready may arrive as late as the WAIT_LIMIT-th cycle of the step.
- FAULT: all control lines 0 and fault=1. Left only by clr=0.
- Read and Write are never both 1. Rin and Rout are never both 1.

## Timing
- Reset (clr=0 at an edge): next state is IDLE, wait counter is 0, and every output is 0 (state=8). clr=0 overrides run and mem_ready, including mid-instruction and in FAULT.
- Latency from run=1 sampled in IDLE: T0 on the next cycle.
- Instruction length with zero-wait memory: ldi 6 cycles, ld 8, st 8. Each memory step adds one cycle per mem_ready=0 cycle.
- Back-to-back instructions: the step after done is T0, with no IDLE bubble, when run=1.
- mem_ready is ignored outside memory steps.
- An illegal opcode costs 4 cycles (T0..T3).

## Test plan
- Reset: hold clr=0 for 2 cycles with run=1 and mem_ready=1 → state=8 and all outputs 0. Release clr → state=0 on the next edge.
- ldi, ir[31:27]=00001, run held 1, mem_ready=1 → states 0,1,2,3,4,5,0. BAout and Grb high only in T3; done high only in T5; PCin high in T1.
- ld with 3 wait cycles in T1 and 2 in T6 → T1 lasts 4 cycles and T6 lasts 3 cycles, 13 cycles in total. Rin high only in T7, together with done.
- st with run dropped during T4 → Write asserted in T7 until mem_ready. done is high in the T7 exit cycle; then state=8 with no new T0.
- Illegal opcode 11111 → illegal pulses for exactly 1 cycle in T3, with no control lines high in T3. Next state is 0 if run=1.
- Timeout, WAIT_LIMIT=15: mem_ready=0 for 15 T1 cycles → state=9 and fault=1 persist through run toggling; clr=0 → IDLE. Repeat with ready on the 15th cycle → proceeds to T2 with no fault.
